// File: rtl/pht_write_scheduler.sv
// PHT write-port scheduler: saturating counter update, bank-conflict-free port grant,
// age-ordered deferral queue and init sweep. Optional drop statistics via PHT_SCHED_DROP_STATS_EN.
module pht_write_scheduler #(
    parameter int ENTRY_NUM   = 2048,
    parameter int ENTRY_WIDTH = 2,
    parameter int REQ_NUM     = 2,
    parameter int BANK_NUM    = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter int INIT_VALUE  = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  initStart,
    output logic                                  initBusy,
    input  logic [REQ_NUM-1:0]                    reqValid,
    input  logic [REQ_NUM*$clog2(ENTRY_NUM)-1:0]  reqIdx,
    input  logic [REQ_NUM-1:0]                    reqTaken,
    input  logic [REQ_NUM*ENTRY_WIDTH-1:0]        reqPrev,
    output logic [REQ_NUM-1:0]                    we,
    output logic [REQ_NUM*$clog2(ENTRY_NUM)-1:0]  wa,
    output logic [REQ_NUM*ENTRY_WIDTH-1:0]        wv,
    output logic [$clog2(QUEUE_DEPTH):0]          queueCount
`ifdef PHT_SCHED_DROP_STATS_EN
    ,
    output logic [31:0]                           dropCount,
    output logic                                  dropPulse
`endif
);

    localparam int IW = $clog2(ENTRY_NUM);
    localparam int VW = ENTRY_WIDTH;
    localparam int BW = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [VW-1:0] VMAX = {VW{1'b1}};

    typedef enum logic {INIT, RUN} state_t;

    state_t          state, nextState;
    logic [IW-1:0]   sweepIdx;
    logic [PW-1:0]   rdPtr, wrPtr;
    logic [CW-1:0]   count;
    logic [IW-1:0]   qIdx [QUEUE_DEPTH];
    logic [VW-1:0]   qVal [QUEUE_DEPTH];

    logic                pop;
    logic                granted;
    logic [REQ_NUM-1:0]  portUsed;
    logic [BANK_NUM-1:0] bankUsed;
    logic [REQ_NUM-1:0]  defer;
    logic [REQ_NUM-1:0]  pushEn;
    logic [PW-1:0]       pushPos [REQ_NUM];
    logic [CW-1:0]       pushN;
    logic [CW-1:0]       freeSlots;
    logic [VW-1:0]       reqNew [REQ_NUM];

    function automatic logic [VW-1:0] satNext(input logic [VW-1:0] prev, input logic taken);
        if (taken) return (prev == VMAX) ? prev : prev + 1'b1;
        else       return (prev == '0)   ? prev : prev - 1'b1;
    endfunction

    function automatic logic [BW-1:0] bankOf(input logic [IW-1:0] idx);
        return BW'(idx & IW'(BANK_NUM - 1));
    endfunction

    for (genvar g = 0; g < REQ_NUM; g++) begin : gNew
        assign reqNew[g] = satNext(reqPrev[g*VW +: VW], reqTaken[g]);
    end

    assign initBusy   = (state == INIT);
    assign queueCount = count;

    always_comb begin
        nextState = state;
        we        = '0;
        wa        = '0;
        wv        = '0;
        pop       = 1'b0;
        granted   = 1'b0;
        portUsed  = '0;
        bankUsed  = '0;
        defer     = '0;
        pushEn    = '0;
        pushN     = '0;
        freeSlots = '0;
        for (int i = 0; i < REQ_NUM; i++) pushPos[i] = '0;

        unique case (state)
            INIT: begin
                we[0]     = 1'b1;
                wa[0 +: IW] = sweepIdx;
                wv[0 +: VW] = VW'(INIT_VALUE);
                if (!initStart && sweepIdx == IW'(ENTRY_NUM - 1)) nextState = RUN;
            end
            RUN: begin
                // Queue head is always the oldest update, so it owns port 0.
                if (count != '0) begin
                    pop         = 1'b1;
                    we[0]       = 1'b1;
                    wa[0 +: IW] = qIdx[rdPtr];
                    wv[0 +: VW] = qVal[rdPtr];
                    portUsed[0] = 1'b1;
                    bankUsed[bankOf(qIdx[rdPtr])] = 1'b1;
                end
                for (int i = 0; i < REQ_NUM; i++) begin
                    if (reqValid[i]) begin
                        granted = 1'b0;
                        if (!bankUsed[bankOf(reqIdx[i*IW +: IW])]) begin
                            for (int p = 0; p < REQ_NUM; p++) begin
                                if (!granted && !portUsed[p]) begin
                                    granted          = 1'b1;
                                    portUsed[p]      = 1'b1;
                                    we[p]            = 1'b1;
                                    wa[p*IW +: IW]   = reqIdx[i*IW +: IW];
                                    wv[p*VW +: VW]   = reqNew[i];
                                end
                            end
                        end
                        if (granted) bankUsed[bankOf(reqIdx[i*IW +: IW])] = 1'b1;
                        else         defer[i] = 1'b1;
                    end
                end
                freeSlots = CW'(QUEUE_DEPTH) - count + CW'(pop);
                for (int i = 0; i < REQ_NUM; i++) begin
                    if (defer[i] && pushN < freeSlots) begin
                        pushEn[i]  = 1'b1;
                        pushPos[i] = wrPtr + PW'(pushN);
                        pushN      = pushN + 1'b1;
                    end
                end
                if (initStart) nextState = INIT;
            end
            default: nextState = INIT;
        endcase

        // Ports are held quiet for as long as reset is asserted.
        if (!rst_n) begin
            we = '0;
            wa = '0;
            wv = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            sweepIdx <= '0;
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
        end else begin
            state <= nextState;
            if (initStart)          sweepIdx <= '0;
            else if (state == INIT) sweepIdx <= sweepIdx + 1'b1;
            if (initStart) begin
                rdPtr <= '0;
                wrPtr <= '0;
                count <= '0;
            end else begin
                rdPtr <= rdPtr + PW'(pop);
                wrPtr <= wrPtr + PW'(pushN);
                count <= count - CW'(pop) + pushN;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < REQ_NUM; i++) begin
            if (pushEn[i]) begin
                qIdx[pushPos[i]] <= reqIdx[i*IW +: IW];
                qVal[pushPos[i]] <= reqNew[i];
            end
        end
    end

`ifdef PHT_SCHED_DROP_STATS_EN
    logic [REQ_NUM-1:0] dropMask;
    logic [32:0]        dropSum;

    assign dropMask  = defer & ~pushEn;
    assign dropPulse = |dropMask;

    always_comb begin
        dropSum = {1'b0, dropCount};
        for (int i = 0; i < REQ_NUM; i++) dropSum = dropSum + 33'(dropMask[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          dropCount <= '0;
        else if (initStart)  dropCount <= '0;
        else if (dropSum[32]) dropCount <= '1;
        else                 dropCount <= dropSum[31:0];
    end
`endif

endmodule

// File: tb/tb_pht_write_scheduler.sv
// Scoreboard bench for pht_write_scheduler with ENTRY_NUM=16; drop-stat checks
// compile in when PHT_SCHED_DROP_STATS_EN is defined.
module tb_pht_write_scheduler;

    localparam int EN = 16;
    localparam int IW = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         initStart;
    logic         initBusy;
    logic [1:0]   reqValid;
    logic [7:0]   reqIdx;
    logic [1:0]   reqTaken;
    logic [3:0]   reqPrev;
    logic [1:0]   we;
    logic [7:0]   wa;
    logic [3:0]   wv;
    logic [2:0]   queueCount;
`ifdef PHT_SCHED_DROP_STATS_EN
    logic [31:0]  dropCount;
    logic         dropPulse;
`endif

    pht_write_scheduler #(.ENTRY_NUM(EN)) dut (
        .clk(clk), .rst_n(rst_n), .initStart(initStart), .initBusy(initBusy),
        .reqValid(reqValid), .reqIdx(reqIdx), .reqTaken(reqTaken), .reqPrev(reqPrev),
        .we(we), .wa(wa), .wv(wv), .queueCount(queueCount)
`ifdef PHT_SCHED_DROP_STATS_EN
        , .dropCount(dropCount), .dropPulse(dropPulse)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int port; int idx; int val; } wr_t;
    wr_t expQ[$];
    int  checks = 0;
    int  failures = 0;
    bit  monEn = 1'b0;

    task automatic checkVal(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int satRef(input int prev, input int taken);
        if (taken != 0) return (prev + 1 > 3) ? 3 : prev + 1;
        return (prev == 0) ? 0 : prev - 1;
    endfunction

    task automatic expWr(input int port, input int idx, input int val);
        wr_t e;
        e.port = port; e.idx = idx; e.val = val;
        expQ.push_back(e);
    endtask

    task automatic expSweep(input int n);
        for (int k = 0; k < n; k++) expWr(0, k, 2);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input int i0, input logic t0, input int p0,
                         input logic v1, input int i1, input logic t1, input int p1);
        reqValid = {v1, v0};
        reqIdx   = {4'(i1), 4'(i0)};
        reqTaken = {t1, t0};
        reqPrev  = {2'(p1), 2'(p0)};
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    always @(negedge clk) begin
        if (monEn) begin
            for (int p = 0; p < 2; p++) begin
                if (we[p]) begin
                    if (expQ.size() == 0) begin
                        checkVal("unexpected_we", p, -1);
                    end else begin
                        wr_t e;
                        e = expQ.pop_front();
                        checkVal("wr_port", p, e.port);
                        checkVal("wr_idx", int'(wa[p*IW +: IW]), e.idx);
                        checkVal("wr_val", int'(wv[p*2 +: 2]), e.val);
                    end
                end
            end
        end
    end

    initial begin
        int qExp [9];
        int j;
        qExp = '{1, 2, 3, 4, 4, 3, 2, 1, 0};
        rst_n = 1'b0; initStart = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_we", int'(we), 0);
        checkVal("rst_wa", int'(wa), 0);
        checkVal("rst_wv", int'(wv), 0);
        checkVal("rst_busy", int'(initBusy), 1);
        checkVal("rst_qcnt", int'(queueCount), 0);

        // Initial sweep after reset release
        monEn = 1'b1;
        expSweep(EN);
        rst_n = 1'b1;
        for (int c = 0; c < EN; c++) begin
            checkVal("sweep_busy", int'(initBusy), 1);
            step();
        end
        checkVal("sweep_end_busy", int'(initBusy), 0);
        checkVal("sweep_sb_empty", expQ.size(), 0);

        // Two banks, both saturate
        drive(1'b1, 4, 1'b1, 3, 1'b1, 7, 1'b0, 0);
        expWr(0, 4, 3); expWr(1, 7, 0);
        step(); idle();
        checkVal("dual_qcnt", int'(queueCount), 0);

        drive(1'b1, 3, 1'b0, 2, 1'b1, 10, 1'b1, 1);
        expWr(0, 3, 1); expWr(1, 10, 2);
        step(); idle();
        checkVal("dual2_qcnt", int'(queueCount), 0);

        // Bank conflict defers the second request
        drive(1'b1, 4, 1'b1, 1, 1'b1, 6, 1'b1, 1);
        expWr(0, 4, 2);
        step(); idle();
        checkVal("conf_qcnt1", int'(queueCount), 1);
        expWr(0, 6, 2);
        step();
        checkVal("conf_qcnt0", int'(queueCount), 0);

        // Head on port 0, new request on port 1, conflicting one deferred
        drive(1'b1, 4, 1'b0, 2, 1'b1, 12, 1'b0, 3);
        expWr(0, 4, 1);
        step();
        checkVal("mix_qcnt_a", int'(queueCount), 1);
        drive(1'b1, 3, 1'b1, 2, 1'b1, 8, 1'b0, 0);
        expWr(0, 12, 2); expWr(1, 3, 3);
        step(); idle();
        checkVal("mix_qcnt_b", int'(queueCount), 1);
        expWr(0, 8, 0);
        step();
        checkVal("mix_qcnt_c", int'(queueCount), 0);

        // Same index twice in one cycle
        drive(1'b1, 5, 1'b1, 0, 1'b1, 5, 1'b0, 2);
        expWr(0, 5, 1);
        step(); idle();
        checkVal("same_qcnt1", int'(queueCount), 1);
        expWr(0, 5, 1);
        step();
        checkVal("same_qcnt0", int'(queueCount), 0);

        // Fill queue to full, then overflow drops request 1
`ifdef PHT_SCHED_DROP_STATS_EN
        checkVal("drop_cnt_pre", int'(dropCount), 0);
`endif
        for (int k = 0; k < 9; k++) expWr(0, (2 * k) % EN, satRef(k % 4, k % 2));
        for (int k = 0; k < 5; k++) begin
            j = 2 * k;
            drive(1'b1, (2 * j) % EN, 1'(j % 2), j % 4,
                  1'b1, (2 * (j + 1)) % EN, 1'((j + 1) % 2), (j + 1) % 4);
            #1;
`ifdef PHT_SCHED_DROP_STATS_EN
            checkVal("drop_pulse", int'(dropPulse), (k == 4) ? 1 : 0);
`endif
            step();
            checkVal("fill_qcnt", int'(queueCount), qExp[k]);
        end
        idle();
`ifdef PHT_SCHED_DROP_STATS_EN
        checkVal("drop_cnt", int'(dropCount), 1);
`endif
        for (int k = 5; k < 9; k++) begin
            step();
            checkVal("drain_qcnt", int'(queueCount), qExp[k]);
        end
        checkVal("fill_sb_empty", expQ.size(), 0);

        // initStart with three entries queued
        for (int k = 0; k < 4; k++) expWr(0, (2 * k + 4) % EN, satRef(k % 4, k % 2));
        for (int k = 0; k < 3; k++) begin
            j = 2 * k;
            drive(1'b1, (2 * j + 4) % EN, 1'(j % 2), j % 4,
                  1'b1, (2 * (j + 1) + 4) % EN, 1'((j + 1) % 2), (j + 1) % 4);
            step();
        end
        idle();
        checkVal("flush_qcnt_pre", int'(queueCount), 3);
        initStart = 1'b1;
        step();
        initStart = 1'b0;
        expSweep(EN);
        checkVal("flush_busy", int'(initBusy), 1);
        checkVal("flush_qcnt", int'(queueCount), 0);
`ifdef PHT_SCHED_DROP_STATS_EN
        checkVal("flush_dropcnt", int'(dropCount), 0);
`endif
        for (int c = 0; c < EN; c++) step();
        checkVal("flush_sweep_busy", int'(initBusy), 0);
        checkVal("flush_sb_empty", expQ.size(), 0);

        // Reset mid-sweep at index 9
        initStart = 1'b1;
        step();
        initStart = 1'b0;
        expSweep(9);
        repeat (9) step();
        checkVal("mid_busy", int'(initBusy), 1);
        rst_n = 1'b0;
        #1;
        checkVal("mid_rst_we", int'(we), 0);
        checkVal("mid_rst_busy", int'(initBusy), 1);
        checkVal("mid_rst_qcnt", int'(queueCount), 0);
        checkVal("mid_sb_empty", expQ.size(), 0);
        repeat (2) step();
        expSweep(EN);
        rst_n = 1'b1;
        for (int c = 0; c < EN; c++) step();
        checkVal("rerun_busy", int'(initBusy), 0);
        checkVal("final_sb_empty", expQ.size(), 0);

        monEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
